regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The module SHALL have parameter W, default 64, giving the register data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 32, giving the number of registers; AW = $clog2(DEPTH).
REQ-003 The module SHALL have parameter NRD, default 2, giving the number of read ports.
REQ-004 The module SHALL have parameter ZERO_REG, default 31, giving the hardwired-zero register index.
REQ-005 The module SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to the read ports, 0 does not.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port ra, input, NRD x AW bits: read address per port.
REQ-009 The module SHALL have port rd, output, NRD x W bits: read data per port.
REQ-010 The module SHALL have port rd_busy, output, NRD bits: the register read by the port has a pending producer.
REQ-011 The module SHALL have ports we_a, wa_a, wd_a, inputs, 1/AW/W bits: write port A (enable, address, data).
REQ-012 The module SHALL have ports we_b, wa_b, wd_b, inputs, 1/AW/W bits: write port B (enable, address, data); B has priority over A.
REQ-013 The module SHALL have ports iss_valid, iss_rd, inputs, 1/AW bits: issue of an instruction that will write iss_rd.
REQ-014 The module SHALL have port pend_cnt, output, AW+1 bits: number of registers currently marked busy.

Function
REQ-015 Reads SHALL be combinational; ra[i] == ZERO_REG SHALL return 0 and rd_busy[i] = 0 regardless of other inputs.
REQ-016 An enabled write to an address other than ZERO_REG SHALL update that register at the rising edge; a write to ZERO_REG SHALL be discarded.
REQ-017 Writes on A and B to the same address in the same cycle SHALL store wd_b only.
REQ-018 When BYPASS=1 and ra[i] matches an enabled, non-ZERO_REG write address, rd[i] SHALL return that write's data, with B taking priority over A; when BYPASS=0, rd[i] SHALL return the stored value.
REQ-019 Addresses >= DEPTH (non-power-of-2 DEPTH) SHALL read 0, SHALL NOT be written, and SHALL never be marked busy.
REQ-020 Each register SHALL have one busy bit; busy is set at the edge when iss_valid = 1 and iss_rd != ZERO_REG.
REQ-021 The busy bit SHALL be cleared at the edge by an enabled write on A or B to that register.
REQ-022 If the same register is set (issue) and cleared (write) in the same cycle, set SHALL win.
REQ-023 rd_busy[i] SHALL equal busy[ra[i]]; when BYPASS=1, rd_busy[i] SHALL be 0 if the same cycle's write clears that register.
REQ-024 pend_cnt SHALL be registered and SHALL equal the population count of the busy bits after each edge; it SHALL be at most DEPTH-1.
REQ-025 rd and rd_busy SHALL have zero-cycle latency; register, busy and pend_cnt updates SHALL have one-cycle latency.

Reset
REQ-026 While reset_n = 0, register k SHALL hold value k, zero-extended to W bits, and ZERO_REG SHALL hold 0, independent of clk.
REQ-027 While reset_n = 0, all busy bits SHALL be 0 and pend_cnt SHALL be 0; writes and issues SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL take effect immediately and discard any same-cycle write or issue; on deassertion, the first rising edge SHALL behave normally.

Verification
REQ-029 Reset release, then read ra = {5, 31} -> rd = {5, 0}, rd_busy = 0, pend_cnt = 0.
REQ-030 we_a = 1, wa_a = 3, wd_a = 0xAAAA, and we_b = 1, wa_b = 3, wd_b = 0x5555 in the same cycle; ra[0] = 3 -> rd[0] = 0x5555 in the write cycle (BYPASS = 1) and on the next cycle.
REQ-031 Write wd_a = 0xFFFF to address 31, then read 31 -> rd = 0; in the issue cycle, iss_rd = 31 -> pend_cnt stays 0.
REQ-032 Issue 7, then the next cycle read ra[1] = 7 -> rd_busy[1] = 1 and pend_cnt = 1; then write 7 via B with ra[1] = 7 -> rd_busy[1] = 0 in the same cycle and pend_cnt = 0 after the edge.
REQ-033 Issue 9 and write 9 in the same cycle -> busy[9] = 1 and pend_cnt = 1; then assert reset_n = 0 between clock edges -> pend_cnt = 0 and register 9 reads 9 immediately.
REQ-034 With BYPASS = 0, write wa_a = 4, wd_a = 0x1234 and read ra[0] = 4 in the same cycle -> rd[0] = 4, then 0x1234 in the next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with a per-register
// scoreboard.
//
// Reads are combinational. When BYPASS is set, a write in the same cycle
// is forwarded to the read ports. Each register has one busy bit. An issue
// sets the bit and a write to that register clears it; if both happen in
// the same cycle, the set wins. pend_cnt is the registered count of busy
// registers.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (register k <- k, scoreboard cleared)
//   ra / rd    NRD read ports: address in, data out
//   rd_busy    busy bit of the register each read port addresses
//   we_a/wa_a/wd_a  write port A
//   we_b/wa_b/wd_b  write port B (wins over A on an address collision)
//   iss_valid/iss_rd  instruction issue that will produce iss_rd
//   pend_cnt   number of busy registers
module regfile_sb #(
  parameter int W        = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NRD-1:0][AW-1:0]   ra,
  output logic [NRD-1:0][W-1:0]    rd,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we_a,
  input  logic [AW-1:0]            wa_a,
  input  logic [W-1:0]             wd_a,
  input  logic                     we_b,
  input  logic [AW-1:0]            wa_b,
  input  logic [W-1:0]             wd_b,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic [AW:0]              pend_cnt
);

  // Population count of the busy vector.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + {{AW{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  logic [DEPTH-1:0][W-1:0] r_regs;
  logic [DEPTH-1:0]        r_busy;
  logic [AW:0]             r_pend_cnt;

  logic [DEPTH-1:0]        w_hit_a;
  logic [DEPTH-1:0]        w_hit_b;
  logic [DEPTH-1:0]        w_iss;
  logic [DEPTH-1:0]        w_busy_nxt;
  logic [NRD-1:0][W-1:0]   w_rd;
  logic [NRD-1:0]          w_rd_busy;

  // Decode writes and issues per register. The zero register and
  // out-of-range addresses never match anything.
  always_comb begin
    w_hit_a    = {DEPTH{1'b0}};
    w_hit_b    = {DEPTH{1'b0}};
    w_iss      = {DEPTH{1'b0}};
    w_busy_nxt = r_busy;
    for (int k = 0; k < DEPTH; k++) begin
      if (k != ZERO_REG) begin
        w_hit_a[k] = we_a && (wa_a == AW'(k));
        w_hit_b[k] = we_b && (wa_b == AW'(k));
        w_iss[k]   = iss_valid && (iss_rd == AW'(k));
      end else begin
        w_hit_a[k] = 1'b0;
        w_hit_b[k] = 1'b0;
        w_iss[k]   = 1'b0;
      end
      // An issue overrides a completing write to the same register.
      if (w_iss[k]) begin
        w_busy_nxt[k] = 1'b1;
      end else if (w_hit_a[k] || w_hit_b[k]) begin
        w_busy_nxt[k] = 1'b0;
      end else begin
        w_busy_nxt[k] = r_busy[k];
      end
    end
  end

  // Register storage: reset loads each register with its own index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= (k == ZERO_REG) ? {W{1'b0}} : W'(k);
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_hit_b[k]) begin
          r_regs[k] <= wd_b;
        end else if (w_hit_a[k]) begin
          r_regs[k] <= wd_a;
        end else begin
          r_regs[k] <= r_regs[k];
        end
      end
    end
  end

  // Scoreboard busy bits and the registered pending count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= {DEPTH{1'b0}};
      r_pend_cnt <= {(AW+1){1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= popcount(w_busy_nxt);
    end
  end

  // Read ports: a one-hot mux over the in-range, non-zero registers, so
  // the zero register and out-of-range addresses fall through to 0.
  // A forwarded write also reports not-busy, because that write retires
  // the pending result.
  always_comb begin
    w_rd      = {(NRD*W){1'b0}};
    w_rd_busy = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((k != ZERO_REG) && (ra[i] == AW'(k))) begin
          if ((BYPASS != 0) && w_hit_b[k]) begin
            w_rd[i]      = wd_b;
            w_rd_busy[i] = 1'b0;
          end else if ((BYPASS != 0) && w_hit_a[k]) begin
            w_rd[i]      = wd_a;
            w_rd_busy[i] = 1'b0;
          end else begin
            w_rd[i]      = r_regs[k];
            w_rd_busy[i] = r_busy[k];
          end
        end else begin
          w_rd[i]      = w_rd[i];
          w_rd_busy[i] = w_rd_busy[i];
        end
      end
    end
  end

  assign rd       = w_rd;
  assign rd_busy  = w_rd_busy;
  assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Two instances share every input:
// u_dut_byp uses BYPASS=1 and u_dut_nob uses BYPASS=0. Both see the same
// writes, so their stored state stays identical; they differ only in
// same-cycle forwarding.
module tb_regfile_sb;

  localparam int W  = 64;
  localparam int AW = 5;

  logic                clk;
  logic                reset_n;
  logic [1:0][AW-1:0]  ra;
  logic                we_a;
  logic [AW-1:0]       wa_a;
  logic [W-1:0]        wd_a;
  logic                we_b;
  logic [AW-1:0]       wa_b;
  logic [W-1:0]        wd_b;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  logic [1:0][W-1:0]   rd_byp;
  logic [1:0]          rd_busy_byp;
  logic [AW:0]         pend_byp;
  logic [1:0][W-1:0]   rd_nob;
  logic [1:0]          rd_busy_nob;
  logic [AW:0]         pend_nob;

  int n_vec;
  int n_err;

  regfile_sb #(.W(64), .DEPTH(32), .NRD(2), .ZERO_REG(31), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_byp), .rd_busy(rd_busy_byp),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .pend_cnt(pend_byp)
  );

  regfile_sb #(.W(64), .DEPTH(32), .NRD(2), .ZERO_REG(31), .BYPASS(0)) u_dut_nob (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_nob), .rd_busy(rd_busy_nob),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .pend_cnt(pend_nob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    we_a      = 1'b0;
    we_b      = 1'b0;
    iss_valid = 1'b0;
  endtask

  // Advance past the next rising edge and let the outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    ra[0]     = 5'd5;
    ra[1]     = 5'd31;
    we_a      = 1'b0;
    wa_a      = 5'd0;
    wd_a      = 64'd0;
    we_b      = 1'b0;
    wa_b      = 5'd0;
    wd_b      = 64'd0;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;

    // During reset: register k holds k, and the zero register holds 0.
    #12;
    check_val("rst_rd0", rd_byp[0], 64'd5);
    check_val("rst_rd1", rd_byp[1], 64'd0);
    check_val("rst_pend", {58'd0, pend_byp}, 64'd0);

    // Release reset between clock edges.
    reset_n = 1'b1;
    tick();
    check_val("rel_rd0", rd_byp[0], 64'd5);
    check_val("rel_rd1", rd_byp[1], 64'd0);
    check_val("rel_busy", {62'd0, rd_busy_byp}, 64'd0);
    check_val("rel_pend", {58'd0, pend_byp}, 64'd0);

    // Same-address collision: B wins, forwarded in the write cycle.
    we_a = 1'b1; wa_a = 5'd3; wd_a = 64'hAAAA;
    we_b = 1'b1; wa_b = 5'd3; wd_b = 64'h5555;
    ra[0] = 5'd3;
    #1;
    check_val("coll_byp", rd_byp[0], 64'h5555);
    check_val("coll_nob", rd_nob[0], 64'd3);
    tick();
    clear_ctl();
    #1;
    check_val("coll_nxt_byp", rd_byp[0], 64'h5555);
    check_val("coll_nxt_nob", rd_nob[0], 64'h5555);

    // A write to the zero register is discarded; an issue to it is ignored.
    we_a = 1'b1; wa_a = 5'd31; wd_a = 64'hFFFF;
    iss_valid = 1'b1; iss_rd = 5'd31;
    ra[0] = 5'd31;
    #1;
    check_val("zr_byp", rd_byp[0], 64'd0);
    check_val("zr_busy", {63'd0, rd_busy_byp[0]}, 64'd0);
    tick();
    clear_ctl();
    #1;
    check_val("zr_nxt", rd_byp[0], 64'd0);
    check_val("zr_pend", {58'd0, pend_byp}, 64'd0);

    // Issue 7, then read busy on the next cycle.
    iss_valid = 1'b1; iss_rd = 5'd7;
    ra[1] = 5'd7;
    #1;
    check_val("iss7_same", {63'd0, rd_busy_byp[1]}, 64'd0);
    tick();
    clear_ctl();
    #1;
    check_val("iss7_busy", {63'd0, rd_busy_byp[1]}, 64'd1);
    check_val("iss7_pend", {58'd0, pend_byp}, 64'd1);
    // A completing write on B clears busy in the same cycle, but only with bypass.
    we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h77;
    #1;
    check_val("wb7_busy_byp", {63'd0, rd_busy_byp[1]}, 64'd0);
    check_val("wb7_busy_nob", {63'd0, rd_busy_nob[1]}, 64'd1);
    check_val("wb7_rd_byp", rd_byp[1], 64'h77);
    check_val("wb7_rd_nob", rd_nob[1], 64'd7);
    tick();
    clear_ctl();
    #1;
    check_val("wb7_pend", {58'd0, pend_byp}, 64'd0);
    check_val("wb7_rd_nxt", rd_nob[1], 64'h77);

    // Build up several pending registers, then retire two at once.
    iss_valid = 1'b1; iss_rd = 5'd1;
    tick();
    iss_rd = 5'd2;
    tick();
    iss_rd = 5'd3;
    tick();
    clear_ctl();
    #1;
    check_val("pend3", {58'd0, pend_byp}, 64'd3);
    we_a = 1'b1; wa_a = 5'd2; wd_a = 64'h22;
    we_b = 1'b1; wa_b = 5'd3; wd_b = 64'h33;
    ra[0] = 5'd2; ra[1] = 5'd3;
    tick();
    clear_ctl();
    #1;
    check_val("pend1", {58'd0, pend_byp}, 64'd1);
    check_val("dual_rd0", rd_byp[0], 64'h22);
    check_val("dual_rd1", rd_byp[1], 64'h33);

    // Retire register 1 so only the next block affects the count.
    we_a = 1'b1; wa_a = 5'd1; wd_a = 64'h11;
    tick();
    clear_ctl();
    #1;
    check_val("pend0", {58'd0, pend_byp}, 64'd0);

    // An issue and a write to the same register in one cycle leave it busy.
    iss_valid = 1'b1; iss_rd = 5'd9;
    we_a = 1'b1; wa_a = 5'd9; wd_a = 64'h99;
    tick();
    clear_ctl();
    ra[0] = 5'd9;
    #1;
    check_val("sw_busy", {63'd0, rd_busy_byp[0]}, 64'd1);
    check_val("sw_pend", {58'd0, pend_byp}, 64'd1);
    check_val("sw_rd", rd_byp[0], 64'h99);

    // Reset asserted between edges takes effect at once.
    reset_n = 1'b0;
    #1;
    check_val("mrst_pend", {58'd0, pend_byp}, 64'd0);
    check_val("mrst_rd9", rd_byp[0], 64'd9);
    check_val("mrst_busy", {63'd0, rd_busy_byp[0]}, 64'd0);
    // Writes and issues are ignored while reset is held.
    we_a = 1'b1; wa_a = 5'd9; wd_a = 64'hDEAD;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    check_val("rsth_rd9", rd_nob[0], 64'd9);
    check_val("rsth_pend", {58'd0, pend_byp}, 64'd0);
    clear_ctl();
    ra[1] = 5'd3;
    #1;
    check_val("rsth_rd3", rd_byp[1], 64'd3);
    reset_n = 1'b1;
    tick();

    // Without bypass, a same-cycle read returns the old value.
    we_a = 1'b1; wa_a = 5'd4; wd_a = 64'h1234;
    ra[0] = 5'd4;
    #1;
    check_val("nob_same", rd_nob[0], 64'd4);
    check_val("byp_same", rd_byp[0], 64'h1234);
    tick();
    clear_ctl();
    #1;
    check_val("nob_nxt", rd_nob[0], 64'h1234);
    check_val("nob_pend", {58'd0, pend_nob}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
